// File: rtl/lif_pkg.sv
// Shared definitions for the synapse-driven LIF neuron.
// Provides the leak-mode selector constants, the accumulator width
// helper used by the synapse adder, and an unsigned clamp function.
package lif_pkg;

   localparam int LEAK_SUB   = 0;
   localparam int LEAK_SHIFT = 1;

   // One sign bit and clog2(N_IN) carry bits on top of the weight width
   // are enough to hold any subset sum of N_IN weights without overflow.
   function automatic int acc_width(input int w_width, input int n_in);
      return w_width + $clog2(n_in) + 1;
   endfunction

   // Clamp a signed value into [0, 2^width-1]; width must stay below 31.
   function automatic logic [31:0] sat_unsigned(input logic signed [31:0] value,
                                                input int                 width);
      logic signed [31:0] max_val;
      max_val = (32'sd1 <<< width) - 32'sd1;
      if (value < 32'sd0) begin
         return '0;
      end else if (value > max_val) begin
         return max_val;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/lif_syn_accum.sv
// Combinational synapse accumulator.
// Sums the signed weights of every synapse whose input spike is set.
// Ports:
//   in_spikes : N_IN spike flags for this time step
//   weights   : flattened signed weights, synapse i at [i*W_WIDTH +: W_WIDTH]
//   syn_sum   : signed sum, wide enough that it never overflows
module lif_syn_accum
   import lif_pkg::*;
#(
   parameter int N_IN    = 4,
   parameter int W_WIDTH = 8,
   parameter int ACC_W   = acc_width(W_WIDTH, N_IN)
) (
   input  logic [N_IN-1:0]         in_spikes,
   input  logic [N_IN*W_WIDTH-1:0] weights,
   output logic signed [ACC_W-1:0] syn_sum
);

   always_comb begin
      syn_sum = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (in_spikes[i]) begin
            syn_sum = syn_sum + ACC_W'($signed(weights[i*W_WIDTH +: W_WIDTH]));
         end
      end
   end

endmodule

// File: rtl/lif_neuron_syn.sv
// Leaky integrate-and-fire neuron with weighted synaptic inputs,
// selectable subtractive or shift-based leak, refractory hold and
// spike-frequency adaptation of the firing threshold.
// State only advances on clk edges where en is high.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   en          : time-step enable
//   in_spikes   : presynaptic spikes for the current step
//   weights     : flattened signed synaptic weights
//   spike       : registered output spike, one clock wide
//   membrane    : membrane potential register
//   refractory  : high while the refractory counter is nonzero
//   thresh_eff  : base threshold plus current adaptation offset
module lif_neuron_syn
   import lif_pkg::*;
#(
   parameter int N_IN              = 4,
   parameter int W_WIDTH           = 8,
   parameter int V_WIDTH           = 12,
   parameter int THRESHOLD         = 100,
   parameter int LEAK_MODE         = LEAK_SUB,
   parameter int LEAK              = 1,
   parameter int REFRACTORY_CYCLES = 4,
   parameter int ADAPT_INC         = 20,
   parameter int ADAPT_MAX         = 200
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [N_IN-1:0]           in_spikes,
   input  logic [N_IN*W_WIDTH-1:0]   weights,
   output logic                      spike,
   output logic [V_WIDTH-1:0]        membrane,
   output logic                      refractory,
   output logic [V_WIDTH:0]          thresh_eff
);

   localparam int ACC_W   = acc_width(W_WIDTH, N_IN);
   localparam int CNT_W   = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;
   localparam int ADAPT_W = (ADAPT_MAX > 0) ? $clog2(ADAPT_MAX + 1) : 1;

   localparam logic [31:0] THRESH_U    = 32'(THRESHOLD);
   localparam logic [31:0] LEAK_U      = 32'(LEAK);
   localparam logic [31:0] ADAPT_INC_U = 32'(ADAPT_INC);
   localparam logic [31:0] ADAPT_MAX_U = 32'(ADAPT_MAX);

   logic                     spike_q,    spike_d;
   logic [V_WIDTH-1:0]       membrane_q, membrane_d;
   logic [CNT_W-1:0]         cnt_q,      cnt_d;
   logic [ADAPT_W-1:0]       adapt_q,    adapt_d;

   logic signed [ACC_W-1:0]  syn_sum;
   logic [31:0]              v_ext;
   logic [31:0]              leaked;
   logic signed [31:0]       v_sum;
   logic [V_WIDTH-1:0]       v_next;
   logic [V_WIDTH:0]         thresh_c;
   logic                     fire;
   logic [31:0]              adapt_inc_full;
   logic [ADAPT_W-1:0]       adapt_on_spike;
   logic [ADAPT_W-1:0]       adapt_decayed;

   lif_syn_accum #(
      .N_IN    (N_IN),
      .W_WIDTH (W_WIDTH),
      .ACC_W   (ACC_W)
   ) u_accum (
      .in_spikes (in_spikes),
      .weights   (weights),
      .syn_sum   (syn_sum)
   );

   // Leak, integration and threshold comparison are evaluated at 32-bit
   // signed width so an inhibitory sum clamps at zero instead of wrapping.
   always_comb begin
      v_ext = 32'(membrane_q);
      if (LEAK_MODE == LEAK_SHIFT) begin
         leaked = v_ext - (v_ext >> LEAK);
      end else begin
         leaked = (v_ext > LEAK_U) ? (v_ext - LEAK_U) : '0;
      end
      v_sum    = $signed(leaked) + 32'(syn_sum);
      v_next   = V_WIDTH'(sat_unsigned(v_sum, V_WIDTH));
      thresh_c = (V_WIDTH + 1)'(THRESH_U + 32'(adapt_q));
      fire     = ({1'b0, v_next} >= thresh_c);

      adapt_inc_full = 32'(adapt_q) + ADAPT_INC_U;
      adapt_on_spike = (adapt_inc_full > ADAPT_MAX_U) ? ADAPT_W'(ADAPT_MAX_U)
                                                      : ADAPT_W'(adapt_inc_full);
      adapt_decayed  = (adapt_q != '0) ? (adapt_q - ADAPT_W'(1)) : adapt_q;
   end

   // Next-state selection: hold when disabled, drain the refractory
   // counter when busy, otherwise integrate and possibly fire. A spike
   // step bumps the adaptation offset and skips that step's decay.
   always_comb begin
      spike_d    = 1'b0;
      membrane_d = membrane_q;
      cnt_d      = cnt_q;
      adapt_d    = adapt_q;
      if (en) begin
         if (cnt_q != '0) begin
            cnt_d      = cnt_q - CNT_W'(1);
            membrane_d = '0;
            adapt_d    = adapt_decayed;
         end else if (fire) begin
            spike_d    = 1'b1;
            membrane_d = '0;
            cnt_d      = CNT_W'(REFRACTORY_CYCLES);
            adapt_d    = adapt_on_spike;
         end else begin
            membrane_d = v_next;
            adapt_d    = adapt_decayed;
         end
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spike_q    <= 1'b0;
         membrane_q <= '0;
         cnt_q      <= '0;
         adapt_q    <= '0;
      end else begin
         spike_q    <= spike_d;
         membrane_q <= membrane_d;
         cnt_q      <= cnt_d;
         adapt_q    <= adapt_d;
      end
   end

   // Outputs are direct views of the state.
   always_comb begin
      spike      = spike_q;
      membrane   = membrane_q;
      refractory = (cnt_q != '0);
      thresh_eff = thresh_c;
   end

endmodule

// File: tb/tb_lif_neuron_syn.sv
// Self-checking bench for lif_neuron_syn.
// Three instances share stimulus: default parameters, a high threshold
// for saturation, and the shift-based leak mode. Each instance is
// tracked by an integer reference model; directed vectors and short
// hand-written sequences add hard-coded expectations on top.
module tb_lif_neuron_syn;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  in_spikes;
   logic [31:0] weights;

   logic        spike_o [3];
   logic [11:0] mem_o   [3];
   logic        ref_o   [3];
   logic [12:0] thr_o   [3];

   typedef struct {
      int v;
      int cnt;
      int adapt;
      int spike;
   } model_t;

   typedef struct {
      bit         en;
      logic [3:0] sp;
      logic [31:0] w;
      int         e_spike;
      int         e_mem;
      int         e_ref;
      int         e_thr;
   } vec_t;

   model_t mdl    [3];
   int     thr_p  [3];
   int     mode_p [3];
   int     leak_p [3];
   vec_t   tbl    [16];

   int n_checks;
   int n_fail;

   lif_neuron_syn dut (
      .clk(clk), .reset(reset), .en(en), .in_spikes(in_spikes), .weights(weights),
      .spike(spike_o[0]), .membrane(mem_o[0]), .refractory(ref_o[0]), .thresh_eff(thr_o[0])
   );

   lif_neuron_syn #(.THRESHOLD(5000)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .in_spikes(in_spikes), .weights(weights),
      .spike(spike_o[1]), .membrane(mem_o[1]), .refractory(ref_o[1]), .thresh_eff(thr_o[1])
   );

   lif_neuron_syn #(.THRESHOLD(1000), .LEAK_MODE(1), .LEAK(2)) dut_shift (
      .clk(clk), .reset(reset), .en(en), .in_spikes(in_spikes), .weights(weights),
      .spike(spike_o[2]), .membrane(mem_o[2]), .refractory(ref_o[2]), .thresh_eff(thr_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void modelReset();
      for (int k = 0; k < 3; k++) begin
         mdl[k].v     = 0;
         mdl[k].cnt   = 0;
         mdl[k].adapt = 0;
         mdl[k].spike = 0;
      end
   endfunction

   // One time step of the neuron's rules in plain integer arithmetic.
   function automatic void modelStep(int k, bit e, logic [3:0] sp, logic [31:0] w);
      int sum;
      int leaked;
      int vn;
      int wv;
      mdl[k].spike = 0;
      if (!e) return;
      if (mdl[k].cnt > 0) begin
         mdl[k].cnt = mdl[k].cnt - 1;
         mdl[k].v   = 0;
         if (mdl[k].adapt > 0) mdl[k].adapt = mdl[k].adapt - 1;
         return;
      end
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         wv = $signed(w[i*8 +: 8]);
         if (sp[i]) sum = sum + wv;
      end
      if (mode_p[k] == 0) leaked = (mdl[k].v > leak_p[k]) ? mdl[k].v - leak_p[k] : 0;
      else                leaked = mdl[k].v - mdl[k].v / (1 << leak_p[k]);
      vn = leaked + sum;
      if (vn < 0)    vn = 0;
      if (vn > 4095) vn = 4095;
      if (vn >= thr_p[k] + mdl[k].adapt) begin
         mdl[k].spike = 1;
         mdl[k].v     = 0;
         mdl[k].cnt   = 4;
         mdl[k].adapt = (mdl[k].adapt + 20 > 200) ? 200 : mdl[k].adapt + 20;
      end else begin
         mdl[k].v = vn;
         if (mdl[k].adapt > 0) mdl[k].adapt = mdl[k].adapt - 1;
      end
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s inst%0d spike", tag, k), int'(spike_o[k]), mdl[k].spike);
         checkOutput($sformatf("%s inst%0d membrane", tag, k), int'(mem_o[k]), mdl[k].v);
         checkOutput($sformatf("%s inst%0d refractory", tag, k), int'(ref_o[k]),
                     (mdl[k].cnt > 0) ? 1 : 0);
         checkOutput($sformatf("%s inst%0d thresh_eff", tag, k), int'(thr_o[k]),
                     thr_p[k] + mdl[k].adapt);
      end
   endtask

   // Drive one step, let the edge happen, then compare every instance
   // against its model shortly after the edge.
   task automatic applyStimulus(input bit e, input logic [3:0] sp, input logic [31:0] w,
                                input string tag);
      en        = e;
      in_spikes = sp;
      weights   = w;
      @(posedge clk);
      for (int k = 0; k < 3; k++) modelStep(k, e, sp, w);
      #1;
      checkAll(tag);
   endtask

   // Pulse reset between edges and verify the outputs react immediately.
   task automatic doReset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s inst%0d spike", tag, k), int'(spike_o[k]), 0);
         checkOutput($sformatf("%s inst%0d membrane", tag, k), int'(mem_o[k]), 0);
         checkOutput($sformatf("%s inst%0d refractory", tag, k), int'(ref_o[k]), 0);
         checkOutput($sformatf("%s inst%0d thresh_eff", tag, k), int'(thr_o[k]), thr_p[k]);
      end
      modelReset();
      #1;
      reset = 1'b0;
   endtask

   function automatic vec_t mk(bit e, logic [3:0] sp, logic [31:0] w,
                               int es, int em, int er, int et);
      vec_t r;
      r.en = e; r.sp = sp; r.w = w;
      r.e_spike = es; r.e_mem = em; r.e_ref = er; r.e_thr = et;
      return r;
   endfunction

   initial begin
      int sat_exp [10];
      int shift_exp [3];

      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      en        = 1'b0;
      in_spikes = '0;
      weights   = '0;
      thr_p  = '{100, 5000, 1000};
      mode_p = '{0, 0, 1};
      leak_p = '{1, 1, 2};

      // Default instance: integrate, fire, refractory drain, gating,
      // inhibitory clamp, and a one-clock-wide spike.
      tbl[0]  = mk(1, 4'b0001, 32'h0000_001E, 0, 30, 0, 100);
      tbl[1]  = mk(1, 4'b0001, 32'h0000_001E, 0, 59, 0, 100);
      tbl[2]  = mk(1, 4'b0001, 32'h0000_001E, 0, 88, 0, 100);
      tbl[3]  = mk(1, 4'b0001, 32'h0000_001E, 1, 0, 1, 120);
      tbl[4]  = mk(1, 4'b0001, 32'h0000_001E, 0, 0, 1, 119);
      tbl[5]  = mk(1, 4'b0001, 32'h0000_001E, 0, 0, 1, 118);
      tbl[6]  = mk(1, 4'b0001, 32'h0000_001E, 0, 0, 1, 117);
      tbl[7]  = mk(1, 4'b0001, 32'h0000_001E, 0, 0, 0, 116);
      tbl[8]  = mk(1, 4'b0001, 32'h0000_001E, 0, 30, 0, 115);
      tbl[9]  = mk(0, 4'b0001, 32'h0000_001E, 0, 30, 0, 115);
      tbl[10] = mk(0, 4'b1111, 32'h7F7F_7F7F, 0, 30, 0, 115);
      tbl[11] = mk(1, 4'b0001, 32'h0000_0015, 0, 50, 0, 114);
      tbl[12] = mk(1, 4'b0010, 32'h0000_B015, 0, 0, 0, 113);
      tbl[13] = mk(1, 4'b0000, 32'h0000_B015, 0, 0, 0, 112);
      tbl[14] = mk(1, 4'b0001, 32'h0000_007F, 1, 0, 1, 132);
      tbl[15] = mk(0, 4'b0001, 32'h0000_007F, 0, 0, 1, 132);

      doReset("reset");
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(tbl[i].en, tbl[i].sp, tbl[i].w, $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d spike", i), int'(spike_o[0]), tbl[i].e_spike);
         checkOutput($sformatf("vec%0d membrane", i), int'(mem_o[0]), tbl[i].e_mem);
         checkOutput($sformatf("vec%0d refractory", i), int'(ref_o[0]), tbl[i].e_ref);
         checkOutput($sformatf("vec%0d thresh_eff", i), int'(thr_o[0]), tbl[i].e_thr);
      end

      // Enable low for ten clocks with active inputs: everything frozen.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 4'b1111, 32'h7F7F_7F7F, "gate");
         checkOutput("gate membrane", int'(mem_o[0]), 0);
         checkOutput("gate refractory", int'(ref_o[0]), 1);
         checkOutput("gate thresh_eff", int'(thr_o[0]), 132);
      end

      // Saturation on the high-threshold instance.
      doReset("reset sat");
      sat_exp = '{508, 1015, 1522, 2029, 2536, 3043, 3550, 4057, 4095, 4095};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 4'b1111, 32'h7F7F_7F7F, "sat");
         checkOutput($sformatf("sat step%0d membrane", i), int'(mem_o[1]), sat_exp[i]);
         checkOutput($sformatf("sat step%0d spike", i), int'(spike_o[1]), 0);
      end

      // Shift leak: load 100, then decay with no inputs.
      doReset("reset shift");
      applyStimulus(1, 4'b0001, 32'h0000_0064, "shift load");
      checkOutput("shift load membrane", int'(mem_o[2]), 100);
      shift_exp = '{75, 57, 43};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 4'b0000, 32'h0000_0064, "shift leak");
         checkOutput($sformatf("shift leak%0d membrane", i), int'(mem_o[2]), shift_exp[i]);
      end

      // Two spikes to build up adaptation, then reset mid-refractory.
      doReset("reset adapt");
      for (int i = 0; i < 6; i++) applyStimulus(1, 4'b0001, 32'h0000_007F, "adapt");
      checkOutput("adapt second spike", int'(spike_o[0]), 1);
      checkOutput("adapt thresh_eff", int'(thr_o[0]), 136);
      applyStimulus(1, 4'b0001, 32'h0000_007F, "adapt refr");
      checkOutput("adapt refr refractory", int'(ref_o[0]), 1);
      checkOutput("adapt refr thresh_eff", int'(thr_o[0]), 135);
      doReset("reset midrefr");

      // Randomized run against the models.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), $urandom,
                       "rand");
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
